cudb_scan_sched: RTL and testbench
==================================

Name: cudb_scan_sched

Overview:
- Sequences up to N_AREA area-scan engines.
- Each engine copies 128 bytes from the channel RAMs into the CUDB maintenance RAM.
- Each engine writes the CUDB port only while it holds the grant; the scheduler muxes those writes onto the single CUDB write port.
- Sits between the console cycle timer / configuration registers and the area-scan engines; reports per-cycle completion and per-area timeout status.

Parameters:
- N_AREA, 4: number of scan engines scheduled.
- TIMEOUT, 512: max cycles from area start to done before abort.
- DRAIN, 6: cycles the grant is held after done, to flush the engine write pipeline.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_cycle_start  in  1  pulse; start one scan cycle
- im_area_en  in  N_AREA  per-area enable, sampled at cycle start
- im_base_addr  in  N_AREA*10  per-area base address, area k at [10k+9:10k]
- om_area_start  out  N_AREA  one-cycle start pulse to engine k
- om_area_base_addr  out  10  base address of the currently launched area
- im_area_done  in  N_AREA  done pulse from engine k
- im_wren  in  N_AREA  engine write enables
- im_waddr  in  N_AREA*13  engine write addresses
- im_wdata  in  N_AREA*8  engine write data
- o_cudb_wren  out  1  CUDB write enable
- om_cudb_addr  out  13  CUDB write address
- om_cudb_din  out  8  CUDB write data
- o_busy  out  1  cycle in progress
- o_cycle_done  out  1  one-cycle pulse at end of cycle
- om_timeout_flags  out  N_AREA  areas that timed out in the last cycle
- o_overrun  out  1  one-cycle pulse; i_cycle_start arrived while busy

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- All outputs reset to 0. FSM resets to IDLE; the enable latch, index and counters are cleared.
- FSM is one-hot: IDLE, LAUNCH, WAIT, DRAIN_S, FINISH.
- IDLE:
  - On i_cycle_start: latch im_area_en into en_q, set idx to the lowest enabled area, clear om_timeout_flags, set o_busy=1.
  - Go to LAUNCH; if en_q==0, go to FINISH instead.
- LAUNCH (1 cycle):
  - om_area_start[idx]=1 for this cycle only.
  - om_area_base_addr = base[idx]; it holds until the next launch.
  - Timeout counter cleared. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - im_area_done[idx] -> DRAIN_S.
  - Counter reaching TIMEOUT-1 without done -> set om_timeout_flags[idx], go to DRAIN_S.
  - Done and timeout in the same cycle: done wins, no flag is set.
  - Done pulses from non-selected areas are ignored.
- DRAIN_S:
  - Hold for exactly DRAIN cycles, then advance idx to the next higher enabled area.
  - If one exists -> LAUNCH; else -> FINISH.
- FINISH (1 cycle): o_cycle_done=1, o_busy=0, go to IDLE.
- Latency from i_cycle_start to o_cycle_done:
  - Empty enable mask: 2 cycles.
  - One area with done at WAIT cycle w (w counted from 1): 1+1+w+DRAIN+1 cycles.
- Grant:
  - The grant is idx, valid in LAUNCH, WAIT and DRAIN_S.
  - The write mux is registered (1 cycle latency): o_cudb_wren = im_wren[idx] & granted; addr and data are taken from slice idx.
  - When not granted: o_cudb_wren=0, addr/din=0.
  - Writes from non-granted engines are dropped silently.
- i_cycle_start while o_busy: ignored, o_overrun pulses for 1 cycle.
- Changes to im_area_en/im_base_addr mid-cycle:
  - The enable mask is not re-sampled (en_q holds).
  - The base address is re-sampled at each LAUNCH.
- idx arithmetic: log2(N_AREA) bits; never wraps within a cycle.
- rst mid-cycle: immediate return to IDLE. No o_cycle_done is issued, and any in-flight engine writes are blocked.

Optional Feature:
- Macro: CUDB_WRGUARD_EN.
- Defined:
  - A granted write is forwarded only if its address is within [{base[idx][8:0],4'd0}, {base[idx][8:0],4'd0}+127].
  - An out-of-window write is dropped (o_cudb_wren stays 0) and sets sticky output o_wrguard_err (extra port, 1 bit).
  - o_wrguard_err is cleared at the next cycle start or by rst.
- Not defined: no address check, and the o_wrguard_err port is absent.

Decomposition:
- Package cudb_sched_pkg holds the FSM one-hot state constants, CUDB_AW=13, CUDB_DW=8 and BASE_W=10.
- One sub-module is natural: cudb_wr_mux, the registered N_AREA:1 write-port mux, including the optional guard.

Test Plan:
- en=4'b0101, base0=10'h010, base2=10'h020, engines done 130 cycles after start:
  - area0 then area2 started; om_area_base_addr = 10'h010 then 10'h020.
  - 256 CUDB writes total; o_cycle_done once; timeout flags 0.
- en=4'b0010, engine1 never asserts done: om_timeout_flags=4'b0010 after 512 WAIT cycles; o_cycle_done follows DRAIN+1 cycles later.
- en=0, i_cycle_start: o_cycle_done exactly 2 cycles later; no om_area_start pulse.
- i_cycle_start pulsed again during WAIT: o_overrun=1 for 1 cycle; the current cycle continues unaffected.
- Engine3 asserts im_wren while area1 is granted: o_cudb_wren stays 0.
  - With CUDB_WRGUARD_EN: a granted write to base+128 is dropped and o_wrguard_err=1.
- rst asserted mid-WAIT: all outputs 0 the next cycle; a later i_cycle_start runs a normal cycle.

Source files
------------

// File: rtl/cudb_sched_pkg.sv
// cudb_sched_pkg: shared widths, one-hot scheduler states and the CUDB write record
package cudb_sched_pkg;
  localparam int CUDB_AW = 13;
  localparam int CUDB_DW = 8;
  localparam int BASE_W = 10;
  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_LAUNCH = 5'b00010;
  localparam logic [4:0] S_WAIT   = 5'b00100;
  localparam logic [4:0] S_DRAIN  = 5'b01000;
  localparam logic [4:0] S_FINISH = 5'b10000;
  typedef struct packed {
    logic                wren;
    logic [CUDB_AW-1:0]  addr;
    logic [CUDB_DW-1:0]  din;
  } cudb_wr_t;
endpackage

// File: rtl/cudb_wr_mux.sv
// cudb_wr_mux: registered N_AREA:1 CUDB write-port mux; with CUDB_WRGUARD_EN defined,
// granted writes outside the 128-byte window of the launched base are dropped and flagged.
module cudb_wr_mux import cudb_sched_pkg::*; #(
  parameter int N_AREA = 4,
  parameter int IW = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_grant,
  input  logic [IW-1:0]               i_idx,
  input  logic [N_AREA-1:0]           im_wren,
  input  logic [N_AREA*CUDB_AW-1:0]   im_waddr,
  input  logic [N_AREA*CUDB_DW-1:0]   im_wdata,
`ifdef CUDB_WRGUARD_EN
  input  logic [8:0]                  i_base,
  input  logic                        i_clr,
  output logic                        o_wrguard_err,
`endif
  output logic                        o_wren,
  output logic [CUDB_AW-1:0]          om_addr,
  output logic [CUDB_DW-1:0]          om_din
);
  logic               w_wen;
  logic               w_fwd;
  logic [CUDB_AW-1:0] w_addr;
  logic [CUDB_DW-1:0] w_data;
  cudb_wr_t           r_out;
  assign w_wen  = i_grant & im_wren[i_idx];
  assign w_addr = im_waddr[int'(i_idx)*CUDB_AW +: CUDB_AW];
  assign w_data = im_wdata[int'(i_idx)*CUDB_DW +: CUDB_DW];
`ifdef CUDB_WRGUARD_EN
  logic [CUDB_AW-1:0] w_lo;
  logic               w_in;
  logic               r_err;
  // window may extend past the top of the RAM; the >= test keeps the subtraction from wrapping
  assign w_lo  = {i_base, 4'd0};
  assign w_in  = (w_addr >= w_lo) && ((w_addr - w_lo) < CUDB_AW'(128));
  assign w_fwd = w_wen & w_in;
  always_ff @(posedge clk) r_err <= !rst && !i_clr && (r_err || (w_wen && !w_in));
  assign o_wrguard_err = r_err;
`else
  assign w_fwd = w_wen;
`endif
  always_ff @(posedge clk)
    r_out <= rst ? '0 : {w_fwd, w_addr & {CUDB_AW{i_grant}}, w_data & {CUDB_DW{i_grant}}};
  assign o_wren  = r_out.wren;
  assign om_addr = r_out.addr;
  assign om_din  = r_out.din;
endmodule

// File: rtl/cudb_scan_sched.sv
// cudb_scan_sched: sequences the area-scan engines one at a time and grants each the CUDB write port.
// Define CUDB_WRGUARD_EN to add the base-window write guard and the o_wrguard_err port.
module cudb_scan_sched import cudb_sched_pkg::*; #(
  parameter int N_AREA = 4,
  parameter int TIMEOUT = 512,
  parameter int DRAIN = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_cycle_start,
  input  logic [N_AREA-1:0]           im_area_en,
  input  logic [N_AREA*BASE_W-1:0]    im_base_addr,
  output logic [N_AREA-1:0]           om_area_start,
  output logic [BASE_W-1:0]           om_area_base_addr,
  input  logic [N_AREA-1:0]           im_area_done,
  input  logic [N_AREA-1:0]           im_wren,
  input  logic [N_AREA*CUDB_AW-1:0]   im_waddr,
  input  logic [N_AREA*CUDB_DW-1:0]   im_wdata,
  output logic                        o_cudb_wren,
  output logic [CUDB_AW-1:0]          om_cudb_addr,
  output logic [CUDB_DW-1:0]          om_cudb_din,
  output logic                        o_busy,
  output logic                        o_cycle_done,
  output logic [N_AREA-1:0]           om_timeout_flags,
`ifdef CUDB_WRGUARD_EN
  output logic                        o_wrguard_err,
`endif
  output logic                        o_overrun
);
  localparam int IW = N_AREA > 1 ? $clog2(N_AREA) : 1;
  localparam int CW = $clog2((TIMEOUT > DRAIN ? TIMEOUT : DRAIN) + 1);
  logic [4:0]        r_state;
  logic [N_AREA-1:0] r_en;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;
  logic [BASE_W-1:0] r_base;
  logic              r_busy;
  logic              r_done;
  logic              r_overrun;
  logic [N_AREA-1:0] r_tflags;
  logic [IW:0]       w_first;
  logic [IW:0]       w_next;
  logic [BASE_W-1:0] w_base_live;
  logic              w_accept;
  logic              w_grant;
  logic              w_done_sel;
  logic              w_tmo;
  logic              w_drain_end;
  // returns {found, lowest set index >= lo}
  function automatic logic [IW:0] pick(input logic [N_AREA-1:0] m, input int lo);
    pick = '0;
    for (int j = N_AREA-1; j >= 0; j--)
      if (m[j] && j >= lo) pick = {1'b1, IW'(j)};
  endfunction
  assign w_first     = pick(im_area_en, 0);
  assign w_next      = pick(r_en, int'(r_idx) + 1);
  assign w_base_live = im_base_addr[int'(r_idx)*BASE_W +: BASE_W];
  assign w_accept    = (r_state == S_IDLE) && i_cycle_start;
  assign w_grant     = |(r_state & (S_LAUNCH | S_WAIT | S_DRAIN));
  assign w_done_sel  = im_area_done[r_idx];
  assign w_tmo       = r_cnt == CW'(TIMEOUT-1);
  assign w_drain_end = r_cnt == CW'(DRAIN-1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_en      <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_base    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_tflags  <= '0;
    end else begin
      r_done    <= 1'b0;
      r_overrun <= i_cycle_start & r_busy;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_en     <= im_area_en;
          r_idx    <= w_first[IW-1:0];
          r_tflags <= '0;
          r_busy   <= 1'b1;
          r_state  <= w_first[IW] ? S_LAUNCH : S_FINISH;
        end
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_base  <= w_base_live;
          r_state <= S_WAIT;
        end
        S_WAIT: if (w_done_sel || w_tmo) begin
          r_cnt   <= '0;
          r_state <= S_DRAIN;
          if (!w_done_sel) r_tflags[r_idx] <= 1'b1;
        end else r_cnt <= r_cnt + 1'b1;
        // grant stays with the finished engine while its write pipeline empties
        S_DRAIN: if (w_drain_end) begin
          r_cnt   <= '0;
          r_idx   <= w_next[IW] ? w_next[IW-1:0] : r_idx;
          r_state <= w_next[IW] ? S_LAUNCH : S_FINISH;
        end else r_cnt <= r_cnt + 1'b1;
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign om_area_start     = (r_state == S_LAUNCH) ? N_AREA'(1) << r_idx : '0;
  assign om_area_base_addr = (r_state == S_LAUNCH) ? w_base_live : r_base;
  assign o_busy            = r_busy;
  assign o_cycle_done      = r_done;
  assign om_timeout_flags  = r_tflags;
  assign o_overrun         = r_overrun;
  cudb_wr_mux #(.N_AREA(N_AREA), .IW(IW)) u_mux (
    .clk           (clk),
    .rst           (rst),
    .i_grant       (w_grant),
    .i_idx         (r_idx),
    .im_wren       (im_wren),
    .im_waddr      (im_waddr),
    .im_wdata      (im_wdata),
`ifdef CUDB_WRGUARD_EN
    .i_base        (om_area_base_addr[8:0]),
    .i_clr         (w_accept),
    .o_wrguard_err (o_wrguard_err),
`endif
    .o_wren        (o_cudb_wren),
    .om_addr       (om_cudb_addr),
    .om_din        (om_cudb_din)
  );
endmodule

// File: tb/tb_cudb_scan_sched.sv
// tb_cudb_scan_sched: table-driven scan cycles against behavioural engines, with a write/start scoreboard
module tb_cudb_scan_sched;
  logic        clk;
  logic        rst;
  logic        i_cycle_start;
  logic [3:0]  im_area_en;
  logic [39:0] im_base_addr;
  logic [3:0]  om_area_start;
  logic [9:0]  om_area_base_addr;
  logic [3:0]  im_area_done = '0;
  logic [3:0]  im_wren = '0;
  logic [51:0] im_waddr = '0;
  logic [31:0] im_wdata = '0;
  logic        o_cudb_wren;
  logic [12:0] om_cudb_addr;
  logic [7:0]  om_cudb_din;
  logic        o_busy;
  logic        o_cycle_done;
  logic [3:0]  om_timeout_flags;
  logic        o_overrun;
`ifdef CUDB_WRGUARD_EN
  logic        o_wrguard_err;
`endif

  cudb_scan_sched #(.N_AREA(4), .TIMEOUT(512), .DRAIN(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_cycle_start     (i_cycle_start),
    .im_area_en        (im_area_en),
    .im_base_addr      (im_base_addr),
    .om_area_start     (om_area_start),
    .om_area_base_addr (om_area_base_addr),
    .im_area_done      (im_area_done),
    .im_wren           (im_wren),
    .im_waddr          (im_waddr),
    .im_wdata          (im_wdata),
    .o_cudb_wren       (o_cudb_wren),
    .om_cudb_addr      (om_cudb_addr),
    .om_cudb_din       (om_cudb_din),
    .o_busy            (o_busy),
    .o_cycle_done      (o_cycle_done),
    .om_timeout_flags  (om_timeout_flags),
`ifdef CUDB_WRGUARD_EN
    .o_wrguard_err     (o_wrguard_err),
`endif
    .o_overrun         (o_overrun)
  );

  typedef struct { logic [12:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [3:0] en; int w; int nwr; logic [3:0] flags; int lat; int nwr_tot; } vec_t;

  int          errs = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          eng_w = 0;
  int          eng_nwr = 0;
  logic        rogue_on = 1'b0;
  int          rogue_k = 0;
  logic [12:0] rogue_addr = '0;
  logic [9:0]  tb_base [4] = '{10'h010, 10'h2a5, 10'h020, 10'h3ff};
  int          eng_t [4];
  logic        eng_act [4];
  wr_t         exp_q [$];
  int          st_q [$];
  vec_t        tv [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // engine models and output scoreboard: sample DUT first, then drive next inputs
  wr_t        m_e;
  int         m_s;
  int         m_t;
  logic [3:0] m_oh;
  initial begin
    for (int k = 0; k < 4; k++) begin eng_t[k] = 0; eng_act[k] = 1'b0; end
    forever begin
      @(negedge clk);
      if (o_cudb_wren) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("wr_unexpected", {19'd0, om_cudb_addr}, 32'hffff_ffff);
        else begin
          m_e = exp_q.pop_front();
          chk("wr_addr", {19'd0, om_cudb_addr}, {19'd0, m_e.addr});
          chk("wr_data", {24'd0, om_cudb_din}, {24'd0, m_e.data});
        end
      end
      if (om_area_start != 4'd0) begin
        if (st_q.size() == 0) chk("start_unexpected", {28'd0, om_area_start}, 32'd0);
        else begin
          m_s  = st_q.pop_front();
          m_oh = 4'(1 << m_s);
          chk("start_area", {28'd0, om_area_start}, {28'd0, m_oh});
          chk("start_base", {22'd0, om_area_base_addr}, {22'd0, tb_base[m_s]});
        end
        for (int k = 0; k < 4; k++) if (om_area_start[k]) begin eng_act[k] = 1'b1; eng_t[k] = -1; end
      end
      im_wren = '0; im_area_done = '0; im_waddr = '0; im_wdata = '0;
      for (int k = 0; k < 4; k++) if (eng_act[k]) begin
        eng_t[k]++;
        m_t = eng_t[k];
        if (m_t >= 1 && m_t <= eng_nwr) begin
          m_e.addr = {tb_base[k][8:0], 4'd0} + 13'(m_t - 1);
          m_e.data = 8'((k * 64) ^ (m_t - 1));
          im_wren[k] = 1'b1;
          im_waddr[k*13 +: 13] = m_e.addr;
          im_wdata[k*8 +: 8] = m_e.data;
          exp_q.push_back(m_e);
        end
        if (eng_w != 0 && m_t == eng_w) begin im_area_done[k] = 1'b1; eng_act[k] = 1'b0; end
        else if (m_t > 600) eng_act[k] = 1'b0;
      end
      if (rogue_on) begin
        im_wren[rogue_k] = 1'b1;
        im_waddr[rogue_k*13 +: 13] = rogue_addr;
        im_wdata[rogue_k*8 +: 8] = 8'hee;
      end
    end
  end

  task automatic start_cycle(input logic [3:0] en);
    im_area_en = en;
    for (int k = 0; k < 4; k++) if (en[k]) st_q.push_back(k);
    i_cycle_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    i_cycle_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    while (!o_cycle_done && cyc - t0 < 3000) @(negedge clk);
    chk("cycle_done", {31'd0, o_cycle_done}, 32'd1);
    lat = cyc - t0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int wr0;
    int lat;
    eng_w = v.w;
    eng_nwr = v.nwr;
    @(negedge clk);
    wr0 = wr_cnt;
    start_cycle(v.en);
    wait_done(lat);
    chk({nm, "_lat"}, lat, v.lat);
    chk({nm, "_flags"}, {28'd0, om_timeout_flags}, {28'd0, v.flags});
    chk({nm, "_busy"}, {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    chk({nm, "_done_pulse"}, {31'd0, o_cycle_done}, 32'd0);
    chk({nm, "_writes"}, wr_cnt - wr0, v.nwr_tot);
    chk({nm, "_starts_left"}, st_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, o_cycle_done}, 32'd0);
    chk({nm, "_start"}, {28'd0, om_area_start}, 32'd0);
    chk({nm, "_base"}, {22'd0, om_area_base_addr}, 32'd0);
    chk({nm, "_wren"}, {31'd0, o_cudb_wren}, 32'd0);
    chk({nm, "_addr"}, {19'd0, om_cudb_addr}, 32'd0);
    chk({nm, "_din"}, {24'd0, om_cudb_din}, 32'd0);
    chk({nm, "_flags"}, {28'd0, om_timeout_flags}, 32'd0);
    chk({nm, "_overrun"}, {31'd0, o_overrun}, 32'd0);
  endtask

  initial begin
    int lat;
    int wr0;
    //          en       w    nwr  flags    lat   writes
    tv[0] = '{4'b0101, 130, 128, 4'b0000,  276, 256};
    tv[1] = '{4'b0010,   0, 128, 4'b0010,  521, 128};
    tv[2] = '{4'b0000,   5,   0, 4'b0000,    2,   0};
    tv[3] = '{4'b1111,   3,   2, 4'b0000,   42,   8};
    tv[4] = '{4'b1000,   1,   1, 4'b0000,   10,   1};
    tv[5] = '{4'b1001, 511,   0, 4'b0000, 1038,   0};
    tv[6] = '{4'b0100, 512,   0, 4'b0000,  521,   0};
    tv[7] = '{4'b0110, 513,   0, 4'b0110, 1040,   0};
    rst = 1'b1;
    i_cycle_start = 1'b0;
    im_area_en = '0;
    for (int k = 0; k < 4; k++) im_base_addr[k*10 +: 10] = tb_base[k];
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tv[i], $sformatf("vec%0d", i));
    chk("base_hold", {22'd0, om_area_base_addr}, {22'd0, tb_base[2]});

    // second start while busy is ignored and flagged
    eng_w = 20; eng_nwr = 0;
    @(negedge clk);
    start_cycle(4'b0001);
    repeat (4) @(negedge clk);
    i_cycle_start = 1'b1;
    @(negedge clk);
    i_cycle_start = 1'b0;
    chk("overrun_pulse", {31'd0, o_overrun}, 32'd1);
    chk("overrun_busy", {31'd0, o_busy}, 32'd1);
    @(negedge clk);
    chk("overrun_clear", {31'd0, o_overrun}, 32'd0);
    wait_done(lat);
    chk("overrun_lat", lat, 29);
    chk("overrun_starts_left", st_q.size(), 0);

    // non-granted engine 3 writes while area 1 owns the port
    eng_w = 12; eng_nwr = 0;
    @(negedge clk);
    start_cycle(4'b0010);
    repeat (3) @(negedge clk);
    wr0 = wr_cnt;
    rogue_k = 3; rogue_addr = 13'h0123; rogue_on = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rogue_wren", {31'd0, o_cudb_wren}, 32'd0);
    end
    rogue_on = 1'b0;
    wait_done(lat);
    chk("rogue_lat", lat, 21);
    chk("rogue_writes", wr_cnt - wr0, 0);

`ifdef CUDB_WRGUARD_EN
    eng_w = 12; eng_nwr = 0;
    @(negedge clk);
    start_cycle(4'b0001);
    repeat (3) @(negedge clk);
    wr0 = wr_cnt;
    rogue_k = 0; rogue_addr = {tb_base[0][8:0], 4'd0} + 13'd128; rogue_on = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("guard_wren", {31'd0, o_cudb_wren}, 32'd0);
    end
    rogue_on = 1'b0;
    chk("guard_err_set", {31'd0, o_wrguard_err}, 32'd1);
    wait_done(lat);
    chk("guard_err_sticky", {31'd0, o_wrguard_err}, 32'd1);
    chk("guard_writes", wr_cnt - wr0, 0);
    @(negedge clk);
    start_cycle(4'b0000);
    chk("guard_err_clr", {31'd0, o_wrguard_err}, 32'd0);
    wait_done(lat);
`endif

    // reset in the middle of WAIT aborts the cycle silently
    eng_w = 50; eng_nwr = 0;
    @(negedge clk);
    start_cycle(4'b0001);
    repeat (10) @(negedge clk);
    chk("rst_pre_busy", {31'd0, o_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrst");
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, o_cycle_done}, 32'd0);
    end
    run_vec('{4'b0001, 5, 4, 4'b0000, 14, 4}, "post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
